// File: rtl/axil_write_arbiter_if.sv
// Bundle of the two requester-side write ports and the shared slave-side port.
// Requester i occupies slice i of every packed S_* vector.
interface axil_write_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [1:0]          S_AWVALID;
  logic [1:0]          S_AWREADY;
  logic [2*ADDR_W-1:0] S_AWADDR;
  logic [5:0]          S_AWPROT;
  logic [1:0]          S_WVALID;
  logic [1:0]          S_WREADY;
  logic [2*DATA_W-1:0] S_WDATA;
  logic [2*STRB_W-1:0] S_WSTRB;
  logic [1:0]          S_BVALID;
  logic [1:0]          S_BREADY;
  logic [3:0]          S_BRESP;

  logic                M_AWVALID;
  logic                M_AWREADY;
  logic [ADDR_W-1:0]   M_AWADDR;
  logic [2:0]          M_AWPROT;
  logic                M_WVALID;
  logic                M_WREADY;
  logic [DATA_W-1:0]   M_WDATA;
  logic [STRB_W-1:0]   M_WSTRB;
  logic                M_BVALID;
  logic                M_BREADY;
  logic [1:0]          M_BRESP;

  logic [1:0]          GRANT;
  logic                BUSY;

  modport slave (
    input  S_AWVALID, S_AWADDR, S_AWPROT,
    input  S_WVALID, S_WDATA, S_WSTRB, S_BREADY,
    output S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
    input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
    output M_AWVALID, M_AWADDR, M_AWPROT,
    output M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
    output GRANT, BUSY
  );

  modport master (
    output S_AWVALID, S_AWADDR, S_AWPROT,
    output S_WVALID, S_WDATA, S_WSTRB, S_BREADY,
    input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
    output M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
    input  M_AWVALID, M_AWADDR, M_AWPROT,
    input  M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
    input  GRANT, BUSY
  );
endinterface

// File: rtl/axil_write_arbiter.sv
// Round-robin arbiter serializing AXI4-Lite write transactions from two
// requesters onto one slave write port; B is routed back to the owner.
module axil_write_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic ACLK,
  input  logic ARESETn,
  axil_write_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   g_q, g_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] s_awready, s_wready, s_bvalid;
  logic [3:0] s_bresp;
  logic       m_awvalid, m_wvalid, m_bready;
  logic       aw_hs, w_hs, busy;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      g_q       <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only AWVALID requests; on a tie the requester not served last wins.
        if (|bus.S_AWVALID) begin
          g_d       = (&bus.S_AWVALID) ? ~last_q : bus.S_AWVALID[1];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        m_awvalid      = bus.S_AWVALID[g_q] & ~aw_done_q;
        s_awready[g_q] = bus.M_AWREADY & ~aw_done_q;
        m_wvalid       = bus.S_WVALID[g_q] & ~w_done_q;
        s_wready[g_q]  = bus.M_WREADY & ~w_done_q;
        aw_hs          = m_awvalid & bus.M_AWREADY;
        w_hs           = m_wvalid & bus.M_WREADY;
        aw_done_d      = aw_done_q | aw_hs;
        w_done_d       = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end
      end
      RESP: begin
        s_bvalid[g_q] = bus.M_BVALID;
        m_bready      = bus.S_BREADY[g_q];
        s_bresp       = {2{bus.M_BRESP}};
        if (bus.M_BVALID && m_bready) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  assign bus.S_AWREADY = s_awready;
  assign bus.S_WREADY  = s_wready;
  assign bus.S_BVALID  = s_bvalid;
  assign bus.S_BRESP   = s_bresp;
  assign bus.M_AWVALID = m_awvalid;
  assign bus.M_WVALID  = m_wvalid;
  assign bus.M_BREADY  = m_bready;
  assign bus.BUSY      = busy;
  assign bus.GRANT     = busy ? {g_q, ~g_q} : 2'b00;

  assign bus.M_AWADDR =
    !busy ? '0 :
    g_q   ? bus.S_AWADDR[2*ADDR_W-1:ADDR_W] :
            bus.S_AWADDR[ADDR_W-1:0];
  assign bus.M_AWPROT =
    !busy ? '0 :
    g_q   ? bus.S_AWPROT[5:3] :
            bus.S_AWPROT[2:0];
  assign bus.M_WDATA =
    !busy ? '0 :
    g_q   ? bus.S_WDATA[2*DATA_W-1:DATA_W] :
            bus.S_WDATA[DATA_W-1:0];
  assign bus.M_WSTRB =
    !busy ? '0 :
    g_q   ? bus.S_WSTRB[2*STRB_W-1:STRB_W] :
            bus.S_WSTRB[STRB_W-1:0];
endmodule

// File: tb/tb_axil_write_arbiter.sv
// Bench for axil_write_arbiter: table of arbitration vectors, directed
// multi-cycle sequences, and a B-response scoreboard.
module tb_axil_write_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axil_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .bus(bus)
  );

  logic [AW-1:0] addr_r[2];
  logic [2:0]    prot_r[2];
  logic [DW-1:0] data_r[2];
  logic [SW-1:0] strb_r[2];

  assign bus.S_AWADDR = {addr_r[1], addr_r[0]};
  assign bus.S_AWPROT = {prot_r[1], prot_r[0]};
  assign bus.S_WDATA  = {data_r[1], data_r[0]};
  assign bus.S_WSTRB  = {strb_r[1], strb_r[0]};

  typedef struct {
    logic          idx;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [1:0]    resp;
  } exp_t;

  typedef struct {
    logic [1:0] awv;
    logic [1:0] bresp;
    logic [1:0] exp_grant;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int checks = 0;
  int failures = 0;

  logic [AW-1:0] obs_addr = '0;
  logic [2:0]    obs_prot = '0;
  logic [DW-1:0] obs_data = '0;
  logic [SW-1:0] obs_strb = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(logic idx, logic [1:0] resp);
    exp_t e;
    e.idx  = idx;
    e.addr = addr_r[idx];
    e.prot = prot_r[idx];
    e.data = data_r[idx];
    e.strb = strb_r[idx];
    e.resp = resp;
    sb.push_back(e);
  endtask

  // Slave-side monitor: capture forwarded AW/W, score each B delivery.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (bus.M_AWVALID && bus.M_AWREADY) begin
        obs_addr = bus.M_AWADDR;
        obs_prot = bus.M_AWPROT;
      end
      if (bus.M_WVALID && bus.M_WREADY) begin
        obs_data = bus.M_WDATA;
        obs_strb = bus.M_WSTRB;
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.S_BVALID[i] && bus.S_BREADY[i]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_b: requester %0d got B, none expected", i);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_owner", 64'(i), 64'(e.idx));
            chk("sb_addr", 64'(obs_addr), 64'(e.addr));
            chk("sb_prot", 64'(obs_prot), 64'(e.prot));
            chk("sb_data", 64'(obs_data), 64'(e.data));
            chk("sb_strb", 64'(obs_strb), 64'(e.strb));
            chk("sb_resp", 64'(bus.S_BRESP[2*i +: 2]), 64'(e.resp));
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.S_AWVALID = '0;
    bus.S_WVALID  = '0;
    bus.S_BREADY  = '0;
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    bus.M_BVALID  = 1'b0;
    bus.M_BRESP   = '0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    step();
  endtask

  // Minimum-latency transaction: grant, AW+W together, immediate B.
  task automatic run_txn(logic [1:0] awv, logic [1:0] bresp, logic [1:0] expg);
    logic idx;
    idx = expg[1];
    bus.S_AWVALID = awv;
    bus.S_WVALID  = awv;
    bus.M_AWREADY = 1'b1;
    bus.M_WREADY  = 1'b1;
    bus.M_BVALID  = 1'b0;
    bus.S_BREADY  = 2'b11;
    bus.M_BRESP   = bresp;
    push(idx, bresp);
    #1;
    chk("txn_idle_busy", 64'(bus.BUSY), 64'(0));
    step();
    chk("txn_grant", 64'(bus.GRANT), 64'(expg));
    chk("txn_m_awvalid", 64'(bus.M_AWVALID), 64'(1));
    chk("txn_m_awaddr", 64'(bus.M_AWADDR), 64'(addr_r[idx]));
    chk("txn_m_wdata", 64'(bus.M_WDATA), 64'(data_r[idx]));
    step();
    bus.S_AWVALID = awv & ~expg;
    bus.S_WVALID  = awv & ~expg;
    bus.M_BVALID  = 1'b1;
    #1;
    chk("txn_s_bvalid", 64'(bus.S_BVALID), 64'(expg));
    chk("txn_s_bresp", 64'(bus.S_BRESP), 64'({bresp, bresp}));
    step();
    bus.M_BVALID = 1'b0;
    #1;
    chk("txn_grant_idle", 64'(bus.GRANT), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b11, 2'b00, 2'b01};
    vecs[1] = '{2'b11, 2'b01, 2'b10};
    vecs[2] = '{2'b11, 2'b10, 2'b01};
    vecs[3] = '{2'b11, 2'b11, 2'b10};
    vecs[4] = '{2'b10, 2'b00, 2'b10};
    vecs[5] = '{2'b01, 2'b10, 2'b01};
    vecs[6] = '{2'b11, 2'b01, 2'b10};
    vecs[7] = '{2'b01, 2'b11, 2'b01};
    vecs[8] = '{2'b11, 2'b00, 2'b10};

    addr_r[0] = 32'h10;  addr_r[1] = 32'h200;
    prot_r[0] = 3'd2;    prot_r[1] = 3'd5;
    data_r[0] = 32'hA5A5A5A5;
    data_r[1] = 32'h5A5A5A5A;
    strb_r[0] = 4'hF;    strb_r[1] = 4'h3;

    // Reset with both requesting: nothing may be granted.
    idle_inputs();
    bus.S_AWVALID = 2'b11;
    bus.M_AWREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #2;
    chk("rst_grant", 64'(bus.GRANT), 64'(0));
    chk("rst_busy", 64'(bus.BUSY), 64'(0));
    chk("rst_m_awvalid", 64'(bus.M_AWVALID), 64'(0));
    chk("rst_s_awready", 64'(bus.S_AWREADY), 64'(0));
    do_reset();

    // Single write from requester 0.
    run_txn(2'b01, 2'b00, 2'b01);

    // Round-robin table from a fresh reset.
    do_reset();
    addr_r[0] = 32'h100;
    for (int v = 0; v < 9; v++) begin
      data_r[0] = $urandom;
      data_r[1] = $urandom;
      run_txn(vecs[v].awv, vecs[v].bresp, vecs[v].exp_grant);
    end
    bus.S_AWVALID = '0;
    bus.S_WVALID  = '0;

    // W before AW on requester 1.
    data_r[1] = $urandom;
    bus.S_WVALID  = 2'b10;
    bus.M_AWREADY = 1'b1;
    bus.M_WREADY  = 1'b1;
    bus.M_BRESP   = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("early_w_wready", 64'(bus.S_WREADY), 64'(0));
      chk("early_w_m_wvalid", 64'(bus.M_WVALID), 64'(0));
      step();
    end
    bus.S_AWVALID = 2'b10;
    push(1'b1, 2'b01);
    #1;
    chk("early_w_idle_wready", 64'(bus.S_WREADY), 64'(0));
    step();
    chk("early_w_grant", 64'(bus.GRANT), 64'(2'b10));
    chk("early_w_wready_granted", 64'(bus.S_WREADY), 64'(2'b10));
    step();
    bus.S_AWVALID = '0;
    bus.S_WVALID  = '0;
    bus.M_BVALID  = 1'b1;
    #1;
    chk("early_w_bvalid", 64'(bus.S_BVALID), 64'(2'b10));
    step();
    bus.M_BVALID = 1'b0;

    // AW handshake in cycle 1, W in cycle 3.
    data_r[0] = $urandom;
    bus.S_AWVALID = 2'b01;
    bus.S_WVALID  = 2'b01;
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    bus.M_BVALID  = 1'b1;
    bus.M_BRESP   = 2'b00;
    bus.S_BREADY  = 2'b11;
    push(1'b0, 2'b00);
    step();
    bus.M_AWREADY = 1'b1;
    #1;
    chk("split_c1_awvalid", 64'(bus.M_AWVALID), 64'(1));
    chk("split_c1_bready", 64'(bus.M_BREADY), 64'(0));
    step();
    chk("split_c2_awvalid", 64'(bus.M_AWVALID), 64'(0));
    chk("split_c2_s_awready", 64'(bus.S_AWREADY), 64'(0));
    chk("split_c2_wvalid", 64'(bus.M_WVALID), 64'(1));
    chk("split_c2_bvalid", 64'(bus.S_BVALID), 64'(0));
    step();
    bus.M_WREADY = 1'b1;
    #1;
    chk("split_c3_s_wready", 64'(bus.S_WREADY), 64'(2'b01));
    chk("split_c3_bready", 64'(bus.M_BREADY), 64'(0));
    step();
    bus.S_AWVALID = '0;
    bus.S_WVALID  = '0;
    #1;
    chk("split_resp_bready", 64'(bus.M_BREADY), 64'(1));
    step();
    bus.M_BVALID = 1'b0;
    #1;
    chk("split_idle_busy", 64'(bus.BUSY), 64'(0));

    // SLVERR with B backpressure from requester 0.
    data_r[0] = $urandom;
    bus.S_AWVALID = 2'b01;
    bus.S_WVALID  = 2'b01;
    bus.M_BVALID  = 1'b1;
    bus.M_BRESP   = 2'b10;
    bus.S_BREADY  = 2'b00;
    push(1'b0, 2'b10);
    step();
    step();
    bus.S_AWVALID = '0;
    bus.S_WVALID  = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_m_bready", 64'(bus.M_BREADY), 64'(0));
      chk("bp_s_bvalid", 64'(bus.S_BVALID), 64'(2'b01));
      chk("bp_s_bresp", 64'(bus.S_BRESP), 64'(4'b1010));
      chk("bp_busy", 64'(bus.BUSY), 64'(1));
      step();
    end
    bus.S_BREADY = 2'b01;
    #1;
    chk("bp_release_bready", 64'(bus.M_BREADY), 64'(1));
    step();
    bus.M_BVALID = 1'b0;
    #1;
    chk("bp_idle_grant", 64'(bus.GRANT), 64'(0));

    // Reset in ADDR_DATA; afterwards a tie goes to requester 0.
    bus.S_AWVALID = 2'b11;
    bus.S_WVALID  = 2'b11;
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    bus.S_BREADY  = 2'b11;
    step();
    chk("mid_rst_grant_before", 64'(bus.GRANT), 64'(2'b10));
    bus.M_AWREADY = 1'b1;
    bus.M_WREADY  = 1'b1;
    #1;
    chk("mid_rst_awready_before", 64'(bus.S_AWREADY), 64'(2'b10));
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(bus.GRANT), 64'(0));
    chk("mid_rst_busy", 64'(bus.BUSY), 64'(0));
    chk("mid_rst_m_awvalid", 64'(bus.M_AWVALID), 64'(0));
    chk("mid_rst_m_wvalid", 64'(bus.M_WVALID), 64'(0));
    chk("mid_rst_s_awready", 64'(bus.S_AWREADY), 64'(0));
    chk("mid_rst_s_wready", 64'(bus.S_WREADY), 64'(0));
    chk("mid_rst_m_awaddr", 64'(bus.M_AWADDR), 64'(0));
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    data_r[0] = $urandom;
    run_txn(2'b11, 2'b11, 2'b01);
    idle_inputs();
    repeat (2) step();

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
